// File: rtl/mem_apb_router.sv
// mem_apb_router: steers core requests to the data cache or to an APB master port,
// with per-slave window decode, access timeout and one-cycle response.
module mem_apb_router #(
   parameter int              XLEN     = 32,
   parameter int              NSLV     = 4,
   parameter logic [XLEN-1:0] APB_BASE = 32'h4000_0000,
   parameter int              SLV_AW   = 12,
   parameter int              TIMEOUT  = 255
) (
   input  logic              m_apb_pclk_i,
   input  logic              m_apb_preset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [XLEN-1:0]   req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   input  logic [XLEN/8-1:0] req_strb_i,
   output logic              resp_valid_o,
   output logic [XLEN-1:0]   resp_rdata_o,
   output logic              resp_err_o,
   output logic [XLEN-1:0]   dcache_addr_o,
   output logic              dcache_read_en_o,
   output logic              dcache_write_en_o,
   output logic [XLEN-1:0]   dcache_write_data_o,
   input  logic [XLEN-1:0]   dcache_read_data_i,
   output logic [XLEN-1:0]   m_apb_paddr_o,
   output logic              m_apb_pwrite_o,
   output logic [NSLV-1:0]   m_apb_psel_o,
   output logic              m_apb_penable_o,
   output logic [XLEN-1:0]   m_apb_pwdata_o,
   output logic [XLEN/8-1:0] m_apb_pstrb_o,
   input  logic              m_apb_pready_i,
   input  logic [XLEN-1:0]   m_apb_prdata_i,
   input  logic              m_apb_pslverr_i
);
   localparam int IW = NSLV > 1 ? $clog2(NSLV) : 1;
   localparam int OW = XLEN - 4 - SLV_AW;
   localparam int CW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
   typedef enum logic [2:0] {IDLE, DC_RESP, SETUP, ACCESS, RESP} state_t;
   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [XLEN-1:0]   paddr_q, pwdata_q, rdata_q;
   logic [XLEN/8-1:0] pstrb_q;
   logic [NSLV-1:0]   psel_q;
   logic              pwrite_q, penable_q, valid_q, err_q;
   logic              accept, is_apb;
   logic [OW-1:0]     slv;
   assign req_ready_o = state_q == IDLE && !m_apb_preset_i;
   assign accept = req_valid_i && req_ready_o;
   assign is_apb = req_addr_i[XLEN-1:XLEN-4] == APB_BASE[XLEN-1:XLEN-4];
   // Whole offset above the slave window is decoded so addresses past the last slave fault instead of aliasing.
   assign slv = req_addr_i[XLEN-5:SLV_AW];
   assign dcache_addr_o = req_addr_i;
   assign dcache_write_data_o = req_wdata_i;
   assign dcache_read_en_o = accept && !is_apb && !req_write_i;
   assign dcache_write_en_o = accept && !is_apb && req_write_i;
   assign resp_valid_o = valid_q;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o = err_q;
   assign m_apb_paddr_o = paddr_q;
   assign m_apb_pwrite_o = pwrite_q;
   assign m_apb_psel_o = psel_q;
   assign m_apb_penable_o = penable_q;
   assign m_apb_pwdata_o = pwdata_q;
   assign m_apb_pstrb_o = pstrb_q;
   always_ff @(posedge m_apb_pclk_i or posedge m_apb_preset_i) begin
      if (m_apb_preset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         rdata_q   <= '0;
         pstrb_q   <= '0;
         psel_q    <= '0;
         pwrite_q  <= 1'b0;
         penable_q <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               if (!is_apb) begin
                  state_q <= DC_RESP;
                  valid_q <= 1'b1;
                  err_q   <= 1'b0;
                  rdata_q <= req_write_i ? '0 : dcache_read_data_i;
               end else if (slv < OW'(NSLV)) begin
                  state_q  <= SETUP;
                  cnt_q    <= '0;
                  paddr_q  <= req_addr_i;
                  pwdata_q <= req_wdata_i;
                  pstrb_q  <= req_write_i ? req_strb_i : '0;
                  pwrite_q <= req_write_i;
                  psel_q   <= NSLV'(1) << slv[IW-1:0];
               end else begin
                  state_q <= RESP;
                  valid_q <= 1'b1;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
            end
            ACCESS: if (m_apb_pready_i || cnt_q == CW'(TIMEOUT - 1)) begin
               state_q   <= RESP;
               psel_q    <= '0;
               penable_q <= 1'b0;
               valid_q   <= 1'b1;
               err_q     <= m_apb_pready_i ? m_apb_pslverr_i : 1'b1;
               rdata_q   <= m_apb_pready_i && !pwrite_q ? m_apb_prdata_i : '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule
